fdma_axi_engine: RTL and testbench

//  Responder side of the FDMA package interface: accepts pkg_wr/pkg_rd burst requests from frame controllers.

---
 rtl/fdma_pkg.sv | 30 +++
 rtl/fdma_axi_engine.sv | 203 ++++++++++++++++++++
 tb/tb_fdma_axi_engine.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fdma_pkg.sv
// Shared constants, state encodings and burst-length helper for the FDMA AXI engine.
package fdma_pkg;

  localparam int MAX_BEAT = 256;

  localparam logic [2:0] AXI_SIZE_16B   = 3'b100;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] AXI_CACHE_DEF  = 4'b0011;
  localparam logic [1:0] RESP_OKAY      = 2'b00;

  typedef enum logic [1:0] {
    W_IDLE,
    W_ADDR,
    W_DATA,
    W_RESP
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA
  } rd_state_e;

  // Zero or oversize requests become a full 256-beat burst.
  function automatic logic [7:0] calc_len(input logic [31:0] size);
    if (size == 32'd0 || size > 32'(MAX_BEAT)) return 8'hFF;
    return 8'(size - 32'd1);
  endfunction

endpackage

// File: rtl/fdma_axi_engine.sv
// FDMA package-interface responder: turns pkg_wr/pkg_rd requests into single
// AXI4 INCR bursts with 16-byte beats; write and read channels run independently.
module fdma_axi_engine
  import fdma_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128
) (
  input  logic                ui_clk,
  input  logic                ui_rst,
  input  logic                pkg_wr_areq,
  input  logic [ADDR_W-1:0]   pkg_wr_addr,
  input  logic [31:0]         pkg_wr_size,
  input  logic [DATA_W-1:0]   pkg_wr_data,
  output logic                pkg_wr_en,
  output logic                pkg_wr_last,
  input  logic                pkg_rd_areq,
  input  logic [ADDR_W-1:0]   pkg_rd_addr,
  input  logic [31:0]         pkg_rd_size,
  output logic [DATA_W-1:0]   pkg_rd_data,
  output logic                pkg_rd_en,
  output logic                pkg_rd_last,
  output logic                wr_busy,
  output logic                rd_busy,
  output logic                wr_err,
  output logic                rd_err,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [7:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [1:0]          m_axi_awburst,
  output logic [3:0]          m_axi_awcache,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [7:0]          m_axi_arlen,
  output logic [2:0]          m_axi_arsize,
  output logic [1:0]          m_axi_arburst,
  output logic [3:0]          m_axi_arcache,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rlast,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready
);

  localparam logic [ADDR_W-1:0] BEAT_MASK = ~ADDR_W'(15);

  wr_state_e         wr_state_q, wr_state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_len_q, wr_len_d, wr_cnt_q, wr_cnt_d;
  logic              wr_err_q, wr_err_d, wr_beat_last;

  rd_state_e         rd_state_q, rd_state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [7:0]        rd_len_q, rd_len_d, rd_cnt_q, rd_cnt_d;
  logic              rd_err_q, rd_err_d, rd_beat_last;

  // NOTE: every combinational output gets a default before the case so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    wr_state_d    = wr_state_q;
    wr_addr_d     = wr_addr_q;
    wr_len_d      = wr_len_q;
    wr_cnt_d      = wr_cnt_q;
    wr_err_d      = wr_err_q;
    wr_beat_last  = (wr_cnt_q == wr_len_q);
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    pkg_wr_en     = 1'b0;
    case (wr_state_q)
      W_IDLE: if (pkg_wr_areq) begin
        wr_addr_d  = pkg_wr_addr & BEAT_MASK;
        wr_len_d   = calc_len(pkg_wr_size);
        wr_cnt_d   = 8'd0;
        wr_state_d = W_ADDR;
      end
      W_ADDR: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) wr_state_d = W_DATA;
      end
      W_DATA: begin
        m_axi_wvalid = 1'b1;
        pkg_wr_en    = m_axi_wready;
        if (m_axi_wready) begin
          wr_cnt_d = wr_cnt_q + 8'd1;
          if (wr_beat_last) begin
            wr_cnt_d   = 8'd0;
            wr_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          if (m_axi_bresp != RESP_OKAY) wr_err_d = 1'b1;
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Read data is pushed unconditionally; the requester reserved FIFO space before areq.
  always_comb begin
    rd_state_d    = rd_state_q;
    rd_addr_d     = rd_addr_q;
    rd_len_d      = rd_len_q;
    rd_cnt_d      = rd_cnt_q;
    rd_err_d      = rd_err_q;
    rd_beat_last  = (rd_cnt_q == rd_len_q);
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    pkg_rd_en     = 1'b0;
    case (rd_state_q)
      R_IDLE: if (pkg_rd_areq) begin
        rd_addr_d  = pkg_rd_addr & BEAT_MASK;
        rd_len_d   = calc_len(pkg_rd_size);
        rd_cnt_d   = 8'd0;
        rd_state_d = R_ADDR;
      end
      R_ADDR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) rd_state_d = R_DATA;
      end
      R_DATA: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid) begin
          pkg_rd_en = 1'b1;
          if (m_axi_rresp != RESP_OKAY || m_axi_rlast != rd_beat_last) rd_err_d = 1'b1;
          rd_cnt_d = rd_cnt_q + 8'd1;
          if (rd_beat_last) begin
            rd_cnt_d   = 8'd0;
            rd_state_d = R_IDLE;
          end
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge ui_clk) begin
    if (ui_rst) begin
      wr_state_q <= W_IDLE;
      wr_addr_q  <= '0;
      wr_len_q   <= '0;
      wr_cnt_q   <= '0;
      wr_err_q   <= 1'b0;
      rd_state_q <= R_IDLE;
      rd_addr_q  <= '0;
      rd_len_q   <= '0;
      rd_cnt_q   <= '0;
      rd_err_q   <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_addr_q  <= wr_addr_d;
      wr_len_q   <= wr_len_d;
      wr_cnt_q   <= wr_cnt_d;
      wr_err_q   <= wr_err_d;
      rd_state_q <= rd_state_d;
      rd_addr_q  <= rd_addr_d;
      rd_len_q   <= rd_len_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_err_q   <= rd_err_d;
    end
  end

  assign m_axi_awaddr  = wr_addr_q;
  assign m_axi_awlen   = wr_len_q;
  assign m_axi_awsize  = AXI_SIZE_16B;
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_awcache = AXI_CACHE_DEF;
  assign m_axi_wdata   = pkg_wr_data;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = m_axi_wvalid & wr_beat_last;
  assign pkg_wr_last   = pkg_wr_en & wr_beat_last;

  assign m_axi_araddr  = rd_addr_q;
  assign m_axi_arlen   = rd_len_q;
  assign m_axi_arsize  = AXI_SIZE_16B;
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arcache = AXI_CACHE_DEF;
  assign pkg_rd_data   = m_axi_rdata;
  assign pkg_rd_last   = pkg_rd_en & rd_beat_last;

  assign wr_busy = (wr_state_q != W_IDLE);
  assign rd_busy = (rd_state_q != R_IDLE);
  assign wr_err  = wr_err_q;
  assign rd_err  = rd_err_q;

endmodule

// File: tb/tb_fdma_axi_engine.sv
// Randomized bench for fdma_axi_engine: a behavioural AXI responder and requester
// FIFO model check burst framing, data order, handshakes and sticky errors.
module tb_fdma_axi_engine;

  localparam int BUDGET = 4000;

  logic         ui_clk = 1'b0;
  logic         ui_rst = 1'b1;
  logic         pkg_wr_areq = 1'b0;
  logic [31:0]  pkg_wr_addr = '0;
  logic [31:0]  pkg_wr_size = '0;
  logic [127:0] pkg_wr_data = '0;
  logic         pkg_wr_en, pkg_wr_last;
  logic         pkg_rd_areq = 1'b0;
  logic [31:0]  pkg_rd_addr = '0;
  logic [31:0]  pkg_rd_size = '0;
  logic [127:0] pkg_rd_data;
  logic         pkg_rd_en, pkg_rd_last;
  logic         wr_busy, rd_busy, wr_err, rd_err;
  logic [31:0]  m_axi_awaddr, m_axi_araddr;
  logic [7:0]   m_axi_awlen, m_axi_arlen;
  logic [2:0]   m_axi_awsize, m_axi_arsize;
  logic [1:0]   m_axi_awburst, m_axi_arburst;
  logic [3:0]   m_axi_awcache, m_axi_arcache;
  logic         m_axi_awvalid, m_axi_arvalid;
  logic         m_axi_awready = 1'b0, m_axi_arready = 1'b0;
  logic [127:0] m_axi_wdata;
  logic [15:0]  m_axi_wstrb;
  logic         m_axi_wlast, m_axi_wvalid;
  logic         m_axi_wready = 1'b0;
  logic [1:0]   m_axi_bresp = 2'b00;
  logic         m_axi_bvalid = 1'b0;
  logic         m_axi_bready;
  logic [127:0] m_axi_rdata = '0;
  logic [1:0]   m_axi_rresp = 2'b00;
  logic         m_axi_rlast = 1'b0, m_axi_rvalid = 1'b0;
  logic         m_axi_rready;

  int vectors = 0;
  int miscompares = 0;
  bit exp_wr_err = 1'b0;
  bit exp_rd_err = 1'b0;

  always #5 ui_clk = ~ui_clk;

  fdma_axi_engine dut (
    .ui_clk(ui_clk), .ui_rst(ui_rst),
    .pkg_wr_areq(pkg_wr_areq), .pkg_wr_addr(pkg_wr_addr), .pkg_wr_size(pkg_wr_size),
    .pkg_wr_data(pkg_wr_data), .pkg_wr_en(pkg_wr_en), .pkg_wr_last(pkg_wr_last),
    .pkg_rd_areq(pkg_rd_areq), .pkg_rd_addr(pkg_rd_addr), .pkg_rd_size(pkg_rd_size),
    .pkg_rd_data(pkg_rd_data), .pkg_rd_en(pkg_rd_en), .pkg_rd_last(pkg_rd_last),
    .wr_busy(wr_busy), .rd_busy(rd_busy), .wr_err(wr_err), .rd_err(rd_err),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awcache(m_axi_awcache),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arcache(m_axi_arcache),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  // Number of beats a request really produces.
  function automatic int eff_beats(input int unsigned size);
    return (size == 0 || size > 256) ? 256 : int'(size);
  endfunction

  task automatic do_wr(input logic [31:0] addr, input int unsigned size, input bit stall,
                       input logic [1:0] bresp, input int abort_at);
    int n = eff_beats(size);
    logic [7:0] exp_len = 8'(n - 1);
    logic [31:0] exp_addr = addr & 32'hFFFF_FFF0;
    logic [127:0] fifo [256];
    int idx = 0;
    int wait_c = 0;
    bit done = 1'b0;
    bit first = 1'b1;
    foreach (fifo[i]) fifo[i] = {$urandom, $urandom, $urandom, $urandom};

    @(negedge ui_clk);
    pkg_wr_areq = 1'b1; pkg_wr_addr = addr; pkg_wr_size = size;
    for (int c = 0; c < BUDGET && !done; c++) begin
      @(negedge ui_clk);
      pkg_wr_areq = 1'b0; pkg_wr_addr = $urandom; pkg_wr_size = $urandom;
      m_axi_awready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (first) begin
        vectors++;
        if (m_axi_awvalid !== 1'b1 || wr_busy !== 1'b1) begin
          miscompares++;
          $display("FAIL aw_latency: awvalid=%b wr_busy=%b one cycle after areq, want 1 1", m_axi_awvalid, wr_busy);
        end
        first = 1'b0;
      end
      if (m_axi_awvalid === 1'b1) begin
        vectors++;
        if (m_axi_awaddr !== exp_addr || m_axi_awlen !== exp_len || m_axi_awsize !== 3'b100 ||
            m_axi_awburst !== 2'b01 || m_axi_awcache !== 4'b0011) begin
          miscompares++;
          $display("FAIL aw_fields: got addr=%h len=%0d size=%b burst=%b cache=%b, want addr=%h len=%0d size=100 burst=01 cache=0011",
                   m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awcache, exp_addr, exp_len);
        end
        if (m_axi_awready) done = 1'b1;
      end
    end
    if (!done) begin
      miscompares++;
      $display("FAIL aw_timeout: no AW handshake within %0d cycles", BUDGET);
      return;
    end

    done = 1'b0;
    for (int c = 0; c < BUDGET && !done; c++) begin
      @(negedge ui_clk);
      m_axi_awready = 1'b0;
      pkg_wr_areq = ($urandom_range(0, 7) == 0);
      pkg_wr_data = fifo[idx];
      m_axi_wready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      vectors++;
      if (m_axi_wvalid !== 1'b1 || pkg_wr_en !== m_axi_wready || m_axi_awvalid !== 1'b0 ||
          m_axi_wstrb !== 16'hFFFF || m_axi_wdata !== fifo[idx]) begin
        miscompares++;
        $display("FAIL w_beat %0d: wvalid=%b wr_en=%b (wready=%b) awvalid=%b strb=%h wdata=%h, want 1 %b 0 ffff %h",
                 idx, m_axi_wvalid, pkg_wr_en, m_axi_wready, m_axi_awvalid, m_axi_wstrb, m_axi_wdata, m_axi_wready, fifo[idx]);
      end
      if (m_axi_wready) begin
        vectors++;
        if (m_axi_wlast !== (idx == n - 1) || pkg_wr_last !== (idx == n - 1)) begin
          miscompares++;
          $display("FAIL w_last beat %0d of %0d: wlast=%b pkg_wr_last=%b, want %b", idx + 1, n,
                   m_axi_wlast, pkg_wr_last, (idx == n - 1));
        end
        idx++;
        if (idx == n || idx == abort_at) done = 1'b1;
      end
    end
    pkg_wr_areq = 1'b0;
    if (!done) begin
      miscompares++;
      $display("FAIL w_timeout: %0d of %0d beats accepted", idx, n);
      return;
    end
    if (abort_at > 0) return;

    wait_c = $urandom_range(0, 3);
    for (int c = 0; c <= wait_c; c++) begin
      @(negedge ui_clk);
      m_axi_wready = 1'b0;
      m_axi_bvalid = (c == wait_c);
      m_axi_bresp  = (c == wait_c) ? bresp : 2'b00;
      #1;
      vectors++;
      if (m_axi_bready !== 1'b1 || wr_busy !== 1'b1 || m_axi_wvalid !== 1'b0) begin
        miscompares++;
        $display("FAIL b_wait: bready=%b wr_busy=%b wvalid=%b, want 1 1 0", m_axi_bready, wr_busy, m_axi_wvalid);
      end
    end
    @(negedge ui_clk);
    m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    #1;
    if (bresp != 2'b00) exp_wr_err = 1'b1;
    vectors++;
    if (wr_busy !== 1'b0 || m_axi_bready !== 1'b0 || wr_err !== exp_wr_err) begin
      miscompares++;
      $display("FAIL b_done: wr_busy=%b bready=%b wr_err=%b, want 0 0 %b", wr_busy, m_axi_bready, wr_err, exp_wr_err);
    end
  endtask

  // rlast_at < 0 means RLAST on the true final beat.
  task automatic do_rd(input logic [31:0] addr, input int unsigned size, input bit gapped,
                       input int rlast_at, input logic [1:0] rresp);
    int n = eff_beats(size);
    int last_at = (rlast_at < 0) ? n - 1 : rlast_at;
    logic [7:0] exp_len = 8'(n - 1);
    logic [31:0] exp_addr = addr & 32'hFFFF_FFF0;
    int idx = 0;
    bit done = 1'b0;
    bit first = 1'b1;

    @(negedge ui_clk);
    pkg_rd_areq = 1'b1; pkg_rd_addr = addr; pkg_rd_size = size;
    for (int c = 0; c < BUDGET && !done; c++) begin
      @(negedge ui_clk);
      pkg_rd_areq = 1'b0; pkg_rd_addr = $urandom; pkg_rd_size = $urandom;
      m_axi_arready = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (first) begin
        vectors++;
        if (m_axi_arvalid !== 1'b1 || rd_busy !== 1'b1) begin
          miscompares++;
          $display("FAIL ar_latency: arvalid=%b rd_busy=%b one cycle after areq, want 1 1", m_axi_arvalid, rd_busy);
        end
        first = 1'b0;
      end
      if (m_axi_arvalid === 1'b1) begin
        vectors++;
        if (m_axi_araddr !== exp_addr || m_axi_arlen !== exp_len || m_axi_arsize !== 3'b100 ||
            m_axi_arburst !== 2'b01 || m_axi_arcache !== 4'b0011 || m_axi_rready !== 1'b0) begin
          miscompares++;
          $display("FAIL ar_fields: got addr=%h len=%0d size=%b burst=%b cache=%b rready=%b, want addr=%h len=%0d 100 01 0011 0",
                   m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arcache, m_axi_rready, exp_addr, exp_len);
        end
        if (m_axi_arready) done = 1'b1;
      end
    end
    if (!done) begin
      miscompares++;
      $display("FAIL ar_timeout: no AR handshake within %0d cycles", BUDGET);
      return;
    end

    done = 1'b0;
    for (int c = 0; c < BUDGET && !done; c++) begin
      @(negedge ui_clk);
      m_axi_arready = 1'b0;
      pkg_rd_areq  = ($urandom_range(0, 7) == 0);
      m_axi_rvalid = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
      m_axi_rdata  = {$urandom, $urandom, $urandom, $urandom};
      m_axi_rresp  = rresp;
      m_axi_rlast  = m_axi_rvalid && (idx == last_at);
      #1;
      vectors++;
      if (m_axi_rready !== 1'b1 || pkg_rd_en !== m_axi_rvalid || pkg_rd_data !== m_axi_rdata ||
          m_axi_arvalid !== 1'b0) begin
        miscompares++;
        $display("FAIL r_beat %0d: rready=%b rd_en=%b (rvalid=%b) arvalid=%b rd_data=%h, want 1 %b 0 %h",
                 idx, m_axi_rready, pkg_rd_en, m_axi_rvalid, m_axi_arvalid, pkg_rd_data, m_axi_rvalid, m_axi_rdata);
      end
      if (m_axi_rvalid) begin
        vectors++;
        if (pkg_rd_last !== (idx == n - 1)) begin
          miscompares++;
          $display("FAIL r_last beat %0d of %0d: pkg_rd_last=%b, want %b", idx + 1, n, pkg_rd_last, (idx == n - 1));
        end
        idx++;
        if (idx == n) done = 1'b1;
      end
    end
    pkg_rd_areq = 1'b0;
    if (!done) begin
      miscompares++;
      $display("FAIL r_timeout: %0d of %0d beats pushed", idx, n);
      return;
    end
    @(negedge ui_clk);
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00;
    #1;
    if (last_at != n - 1 || rresp != 2'b00) exp_rd_err = 1'b1;
    vectors++;
    if (rd_busy !== 1'b0 || m_axi_rready !== 1'b0 || rd_err !== exp_rd_err) begin
      miscompares++;
      $display("FAIL r_done: rd_busy=%b rready=%b rd_err=%b, want 0 0 %b", rd_busy, m_axi_rready, rd_err, exp_rd_err);
    end
  endtask

  task automatic check_quiet(input string name);
    logic [12:0] ctl;
    ctl = {m_axi_awvalid, m_axi_wvalid, m_axi_wlast, pkg_wr_en, pkg_wr_last, m_axi_bready,
           m_axi_arvalid, m_axi_rready, pkg_rd_en, pkg_rd_last, wr_busy, rd_busy, wr_err | rd_err};
    vectors++;
    if (ctl !== 13'd0) begin
      miscompares++;
      $display("FAIL %s: control vector {awv,wv,wlast,wen,wlast_p,bready,arv,rready,ren,rlast_p,wbusy,rbusy,err}=%b, want all 0", name, ctl);
    end
  endtask

  task automatic test_reset();
    ui_rst = 1'b1;
    m_axi_wready = 1'b1; m_axi_rvalid = 1'b1;
    repeat (3) @(negedge ui_clk);
    #1;
    check_quiet("reset_hold");
    @(negedge ui_clk);
    ui_rst = 1'b0; m_axi_wready = 1'b0; m_axi_rvalid = 1'b0;
    @(negedge ui_clk);
    #1;
    check_quiet("reset_idle");
  endtask

  task automatic test_wr_full();
    do_wr(32'h1000_0000, 256, 1'b0, 2'b00, 0);
  endtask

  task automatic test_wr_stall();
    do_wr(32'h1000_1000, 256, 1'b1, 2'b00, 0);
    do_wr(32'h1000_2008, 1, 1'b1, 2'b00, 0);
  endtask

  task automatic test_rd_gapped();
    do_rd(32'h2000_010F, 16, 1'b1, -1, 2'b00);
    do_rd(32'h2000_1000, 1, 1'b1, -1, 2'b00);
  endtask

  task automatic test_simultaneous();
    fork
      do_wr(32'h3000_0000, 64, 1'b1, 2'b00, 0);
      do_rd(32'h4000_0000, 32, 1'b1, -1, 2'b00);
    join
  endtask

  task automatic test_errors();
    do_wr(32'h6000_0000, 8, 1'b0, 2'b10, 0);
    do_wr(32'h6000_1000, 4, 1'b1, 2'b00, 0);
    do_rd(32'h6000_2000, 16, 1'b1, 14, 2'b00);
    do_wr(32'h6000_3000, 0, 1'b1, 2'b00, 0);
    do_rd(32'h6000_4000, 300, 1'b0, -1, 2'b00);
  endtask

  task automatic test_reset_midburst();
    do_wr(32'h5000_0000, 256, 1'b0, 2'b00, 100);
    @(negedge ui_clk);
    ui_rst = 1'b1; m_axi_wready = 1'b1;
    @(negedge ui_clk);
    ui_rst = 1'b0;
    #1;
    exp_wr_err = 1'b0; exp_rd_err = 1'b0;
    check_quiet("reset_midburst");
    m_axi_wready = 1'b0;
    do_wr(32'h5000_1000, 12, 1'b1, 2'b00, 0);
    do_rd(32'h5000_2000, 20, 1'b1, -1, 2'b00);
  endtask

  initial begin
    test_reset();
    test_wr_full();
    test_wr_stall();
    test_rd_gapped();
    test_simultaneous();
    test_errors();
    test_reset_midburst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
